// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// xfer_cycles gives the accept-to-done latency of one transfer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam logic [3:0] DEF_PAT = 4'b1100;

    function automatic int xfer_cycles(input int pat_w, input int rep, input int gap);
        if (rep == 0) return 1;
        return pat_w * rep + gap * (rep - 1) + 1;
    endfunction

endpackage

// File: rtl/seq_gen_tx_if.sv
// Descriptor handshake and serial output bundle of seq_gen_tx.
// The transmitter is the slave; the stimulus source is the master.
interface seq_gen_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             o;
    logic             o_valid;
    logic             o_last;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, pattern, repeat_cnt, gap_len, abort,
        input  start_ready, o, o_valid, o_last, busy, done
    );

    modport slave (
        input  start_valid, pattern, repeat_cnt, gap_len, abort,
        output start_ready, o, o_valid, o_last, busy, done
    );
endinterface

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shift register, MSB out first, zero fill.
// Clear has priority over load, load over shift.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] par_i,
    output logic         ser_o
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr_i)        sr_d = '0;
        else if (load_i)  sr_d = par_i;
        else if (shift_i) sr_d = {sr_q[W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign ser_o = sr_q[W-1];
endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for a
// programmed number of copies, with an optional idle gap between copies.
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = seq_pkg::DEF_PAT,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_gen_tx_if.slave bus
);
    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] copies_q, copies_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             piso_clr, piso_load, piso_shift;
    logic [PAT_W-1:0] piso_din;
    logic             ser;
    logic             accept;
    logic             to_idle;

    // ready_q is only high in IDLE, so this also qualifies the state
    assign accept = bus.start_valid & ready_q & ~bus.abort;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        copies_d   = copies_q;
        gap_cnt_d  = gap_cnt_q;
        gap_len_d  = gap_len_q;
        pat_d      = pat_q;
        o_valid_d  = o_valid_q;
        o_last_d   = o_last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
        piso_clr   = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = pat_q;
        to_idle    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pat_d     = bus.pattern;
                    gap_len_d = bus.gap_len;
                    if (bus.repeat_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = SHIFT;
                        copies_d  = bus.repeat_cnt;
                        piso_load = 1'b1;
                        piso_din  = bus.pattern;
                        idx_d     = IDX_MSB;
                        o_valid_d = 1'b1;
                        o_last_d  = 1'b0;
                        busy_d    = 1'b1;
                        ready_d   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    to_idle = 1'b1;
                end else if (idx_q != '0) begin
                    piso_shift = 1'b1;
                    idx_d      = idx_q - 1'b1;
                    o_last_d   = (idx_q == IDX_W'(1));
                end else begin
                    copies_d = copies_q - 1'b1;
                    if (copies_q == CNT_W'(1)) begin
                        to_idle = 1'b1;
                        done_d  = 1'b1;
                    end else if (gap_len_q == '0) begin
                        piso_load = 1'b1;
                        idx_d     = IDX_MSB;
                        o_last_d  = 1'b0;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                        piso_clr  = 1'b1;
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    to_idle = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SHIFT;
                    piso_load = 1'b1;
                    idx_d     = IDX_MSB;
                    o_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (to_idle) begin
            state_d   = IDLE;
            copies_d  = '0;
            gap_cnt_d = '0;
            piso_clr  = 1'b1;
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            copies_q  <= '0;
            gap_cnt_q <= '0;
            gap_len_q <= '0;
            pat_q     <= DEF_PAT;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            copies_q  <= copies_d;
            gap_cnt_q <= gap_cnt_d;
            gap_len_q <= gap_len_d;
            pat_q     <= pat_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    seq_piso #(.W(PAT_W)) u_piso (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (piso_clr),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .par_i   (piso_din),
        .ser_o   (ser)
    );

    assign bus.o           = ser;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_last      = o_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.start_ready = ready_q;
endmodule

// File: tb/tb_seq_gen_tx.sv
// Self-checking bench for seq_gen_tx: a per-cycle expectation list built
// from the transfer rules, plus literal checks of bits, counts and latency.
module tb_seq_gen_tx;
    import seq_pkg::*;

    localparam int PAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_gen_tx_if #(.PAT_W(PAT_W), .CNT_W(8), .GAP_W(4)) bus ();

    seq_gen_tx #(.PAT_W(PAT_W), .CNT_W(8), .GAP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic o;
        logic v;
        logic last;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    localparam exp_t IDLE_E = exp_t'(6'b000001);
    localparam exp_t GAP_E  = exp_t'(6'b000100);
    localparam exp_t DONE_E = exp_t'(6'b000011);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outputs for every cycle after an accept, derived from the rules
    exp_t q[$];
    exp_t cur = IDLE_E;
    int   cyc = 0;
    int   acc_cyc = 0;

    function automatic void build(input logic [PAT_W-1:0] p, input int rep, input int gap);
        for (int c = 0; c < rep; c++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                q.push_back(exp_t'({p[b], 1'b1, (b == 0), 1'b1, 1'b0, 1'b0}));
            if (c < rep - 1)
                for (int g = 0; g < gap; g++) q.push_back(GAP_E);
        end
        q.push_back(DONE_E);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            cur = IDLE_E;
        end else begin
            cyc++;
            if (cur.busy && bus.abort) begin
                q.delete();
            end else if (cur.ready && bus.start_valid && !bus.abort) begin
                acc_cyc = cyc - 1;
                build(bus.pattern, int'(bus.repeat_cnt), int'(bus.gap_len));
            end
            cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
        end
    end

    logic bits[$];
    int   nvalid = 0;
    int   done_seen = 0;
    int   done_lat = -1;

    always @(negedge clk) begin
        if (rst) begin
            check("o",           int'(bus.o),           int'(cur.o));
            check("o_valid",     int'(bus.o_valid),     int'(cur.v));
            check("o_last",      int'(bus.o_last),      int'(cur.last));
            check("busy",        int'(bus.busy),        int'(cur.busy));
            check("done",        int'(bus.done),        int'(cur.done));
            check("start_ready", int'(bus.start_ready), int'(cur.ready));
            if (bus.o_valid) begin
                bits.push_back(bus.o);
                nvalid++;
            end
            if (bus.done) begin
                done_seen++;
                done_lat = cyc - acc_cyc;
            end
        end
    end

    task automatic clr_mon();
        bits.delete();
        nvalid    = 0;
        done_seen = 0;
        done_lat  = -1;
    endtask

    task automatic send(input logic [PAT_W-1:0] p, input int rep, input int gap);
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.pattern     = p;
        bus.repeat_cnt  = 8'(rep);
        bus.gap_len     = 4'(gap);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (done_seen == 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (done_seen == 0) check("done_timeout", 0, 1);
    endtask

    function automatic int packbits();
        int v = 0;
        foreach (bits[i]) v = (v << 1) | int'(bits[i]);
        return v;
    endfunction

    function automatic int hits_1100();
        int h = 0;
        int i = 0;
        while (i + 3 < bits.size()) begin
            if ({bits[i], bits[i+1], bits[i+2], bits[i+3]} == 4'b1100) begin
                h++;
                i += 4;
            end else begin
                i++;
            end
        end
        return h;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start_valid = 1'b0;
        bus.pattern     = '0;
        bus.repeat_cnt  = '0;
        bus.gap_len     = '0;
        bus.abort       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready",   int'(bus.start_ready), 1);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_pat",     int'(dut.pat_q), 'hC);

        clr_mon();
        send(4'b1100, 1, 0);
        wait_done(20);
        check("t1_bits",   packbits(), 'hC);
        check("t1_nvalid", nvalid, 4);
        check("t1_lat",    done_lat, 5);
        check("t1_lat_fn", done_lat, xfer_cycles(PAT_W, 1, 0));

        clr_mon();
        send(4'b1100, 3, 0);
        wait_done(40);
        check("t2_bits",   packbits(), 'hCCC);
        check("t2_nvalid", nvalid, 12);
        check("t2_lat",    done_lat, 13);
        check("t2_hits",   hits_1100(), 3);

        clr_mon();
        send(4'b1100, 2, 2);
        wait_done(40);
        check("t3_bits",   packbits(), 'hCC);
        check("t3_nvalid", nvalid, 8);
        check("t3_lat",    done_lat, 11);
        check("t3_lat_fn", done_lat, xfer_cycles(PAT_W, 2, 2));

        clr_mon();
        send(4'b1010, 0, 3);
        wait_done(10);
        check("t4_lat", done_lat, 1);
        repeat (5) @(negedge clk);
        check("t4_nvalid", nvalid, 0);
        check("t4_ready",  int'(bus.start_ready), 1);

        clr_mon();
        send(4'b1100, 2, 0);
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.pattern     = 4'b1010;
        bus.repeat_cnt  = 8'd5;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        wait_done(40);
        repeat (10) @(negedge clk);
        check("t5_nvalid", nvalid, 8);
        check("t5_bits",   packbits(), 'hCC);
        check("t5_done",   done_seen, 1);

        clr_mon();
        send(4'b1100, 2, 0);
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        @(negedge clk);
        check("t6_ready",   int'(bus.start_ready), 1);
        check("t6_o_valid", int'(bus.o_valid), 0);
        repeat (12) @(negedge clk);
        check("t6_nvalid", nvalid, 2);
        check("t6_done",   done_seen, 0);

        clr_mon();
        @(posedge clk); #1;
        bus.start_valid = 1'b1;
        bus.abort       = 1'b1;
        bus.pattern     = 4'b1111;
        bus.repeat_cnt  = 8'd1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        repeat (10) @(negedge clk);
        check("t7_nvalid", nvalid, 0);
        check("t7_done",   done_seen, 0);

        clr_mon();
        send(4'b1011, 3, 1);
        #2;
        check("t8_pre_o",    int'(bus.o), 1);
        check("t8_pre_busy", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("t8_o",       int'(bus.o), 0);
        check("t8_o_valid", int'(bus.o_valid), 0);
        check("t8_busy",    int'(bus.busy), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("t8_pat",   int'(dut.pat_q), 'hC);
        check("t8_ready", int'(bus.start_ready), 1);
        repeat (20) @(negedge clk);
        check("t8_done", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_gen_tx.md
Name: seq_gen_tx

Overview:
- Serial pattern transmitter. It is the stimulus/driver end for the team's serial sequence detectors.
- Accepts a pattern descriptor over a valid/ready handshake, then emits the pattern MSB-first, one bit per clock, for a programmed number of copies.
- An optional idle gap can be inserted between copies.
- A per-copy last-bit marker lets downstream logic or a scoreboard align expected detector hits.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- DEF_PAT, 4'b1100, pattern loaded at reset into the pattern register (PAT_W bits).
- CNT_W, 8, width of the repeat counter.
- GAP_W, 4, width of the inter-copy gap length.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_valid  input  1  descriptor valid.
- start_ready  output  1  descriptor accepted when start_valid && start_ready.
- pattern  input  PAT_W  bits to send, MSB first.
- repeat_cnt  input  CNT_W  number of copies; 0 means no bits are sent.
- gap_len  input  GAP_W  idle cycles between copies; 0 means back-to-back.
- abort  input  1  synchronous cancel of the current transfer.
- o  output  1  serial data bit.
- o_valid  output  1  o carries a pattern bit this cycle.
- o_last  output  1  o is the final (LSB) bit of a copy.
- busy  output  1  transfer in progress (SHIFT or GAP).
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; the pattern register takes DEF_PAT; counters clear.
  - o=0, o_valid=0, o_last=0, busy=0, done=0, start_ready=1 after release.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start_ready=1; o=0, o_valid=0.
  - On accept, pattern, repeat_cnt and gap_len are captured.
  - If repeat_cnt=0: stay IDLE and pulse done in the next cycle. No o_valid.
  - Otherwise go to SHIFT. The first bit (pattern[PAT_W-1]) appears on o with o_valid=1 in the cycle after the accept (latency 1).
- SHIFT:
  - One bit per cycle, MSB to LSB. The bit index counts PAT_W-1 down to 0.
  - o_last=1 when the index is 0.
  - After the LSB:
    - If copies remain and gap_len=0, the next copy's MSB goes out in the following cycle with no bubble.
    - If copies remain and gap_len>0, go to GAP.
    - If no copies remain, go to IDLE and assert done=1 in the cycle after the final bit.
- GAP:
  - Exactly gap_len cycles with o=0, o_valid=0, busy=1; then return to SHIFT with the MSB.
- start_ready=0 whenever busy. start_valid while busy is ignored and never queued.
- abort (SHIFT or GAP): next cycle state=IDLE, o=0, o_valid=0, o_last=0, no done pulse, captured descriptor discarded.
  - abort in IDLE has no effect.
  - abort and an accept in the same IDLE cycle: abort wins and the start is dropped.
- Copy counter: loaded with repeat_cnt and decremented on each o_last. Max 2^CNT_W-1 copies, no wrap.
- Reset mid-transfer: immediate return to the reset values. No done pulse.
- Total o_valid cycles for one transfer = PAT_W*repeat_cnt.
- Cycles from accept to done = PAT_W*repeat_cnt + gap_len*(repeat_cnt-1) + 1.

Decomposition:
- Package seq_pkg:
  - state encoding localparams (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10);
  - DEF_PAT constant;
  - a function returning the expected transfer length, for use by the bench.
- One sub-module, seq_piso: a PAT_W-bit parallel-in/serial-out shift register with load, shift and clear. The FSM, copy counter and gap counter stay in seq_gen_tx.

Test Plan:
- pattern=1100, repeat_cnt=1, gap_len=0, accept at cycle 0:
  - o=1,1,0,0 with o_valid=1 in cycles 1-4;
  - o_last only in cycle 4; done in cycle 5;
  - start_ready=0 in cycles 1-4.
- pattern=1100, repeat_cnt=3, gap_len=0:
  - 12 contiguous bits 110011001100;
  - o_last in cycles 4, 8, 12; done in cycle 13.
  - Feeding o into a 1100 detector gives 3 hits in non-overlap mode.
- pattern=1100, repeat_cnt=2, gap_len=2:
  - bits in cycles 1-4, o_valid=0 in cycles 5-6, bits in cycles 7-10;
  - done in cycle 11.
- repeat_cnt=0:
  - done in cycle 1, o_valid never asserts, start_ready stays 1.
  - A second start_valid asserted in cycle 2 of a repeat_cnt=2 transfer is ignored: exactly 8 bits are sent.
- abort in cycle 2 of a 1100 x2 transfer:
  - o_valid=0 from cycle 3, no done, start_ready=1 in cycle 3.
  - abort together with start_valid in IDLE produces no transfer.
- rst pulled low asynchronously mid-SHIFT (between edges):
  - o, o_valid, busy drop to 0 immediately.
  - After release the pattern register equals DEF_PAT and start_ready=1.
